law_checker: RTL



---
 rtl/law_checker_if.sv | 28 ++
 rtl/law_checker.sv | 112 +++++++++++
 2 files changed

// File: rtl/law_checker_if.sv
// Stimulus/response bundle between a Boolean-law sweep driver and law_checker.
// The driver side (master) supplies the vector and the four law-circuit
// outputs; the checker side (slave) returns status and captured results.
interface law_checker_if #(
    parameter int ERRW = 8
);
    logic             start;
    logic             valid;
    logic [2:0]       vec;
    logic [3:0]       s;
    logic             busy;
    logic             done;
    logic             pass;
    logic [7:0]       cov;
    logic [ERRW-1:0]  err_cnt;
    logic [2:0]       first_err_vec;
    logic [1:0]       first_err_pair;

    modport master (
        output start, valid, vec, s,
        input  busy, done, pass, cov, err_cnt, first_err_vec, first_err_pair
    );

    modport slave (
        input  start, valid, vec, s,
        output busy, done, pass, cov, err_cnt, first_err_vec, first_err_pair
    );
endinterface

// File: rtl/law_checker.sv
// Response monitor for the exhaustive 3-input law sweep: compares the
// associative pair s[1:0] and the commutative pair s[3:2] on every sample,
// tracks vector coverage, counts mismatches and captures the first one.
module law_checker #(
    parameter int ERRW = 8
) (
    input  logic         clk,
    input  logic         rst,
    law_checker_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [ERRW-1:0] ERR_MAX = {ERRW{1'b1}};

    state_t           state_reg, state_next;
    logic [7:0]       cov_reg, cov_next;
    logic [ERRW-1:0]  err_cnt_reg, err_cnt_next;
    logic [2:0]       first_err_vec_reg, first_err_vec_next;
    logic [1:0]       first_err_pair_reg, first_err_pair_next;

    logic [7:0]       vec_hit;
    logic [7:0]       cov_upd;
    logic [1:0]       mism;
    logic             sample;
    logic             busy_o, done_o, pass_o;

    // One-hot decode of the incoming vector for the coverage bitmap.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_hit
            assign vec_hit[gi] = (bus.vec == 3'(gi));
        end
    endgenerate

    // bit1: commutative pair differs, bit0: associative pair differs.
    assign mism    = {bus.s[3] ^ bus.s[2], bus.s[1] ^ bus.s[0]};
    assign cov_upd = cov_reg | vec_hit;
    // start has priority: a sample arriving with start is dropped.
    assign sample  = (state_reg == RUN) && bus.valid && !bus.start;

    // State and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg          <= IDLE;
            cov_reg            <= '0;
            err_cnt_reg        <= '0;
            first_err_vec_reg  <= '0;
            first_err_pair_reg <= '0;
        end else begin
            state_reg          <= state_next;
            cov_reg            <= cov_next;
            err_cnt_reg        <= err_cnt_next;
            first_err_vec_reg  <= first_err_vec_next;
            first_err_pair_reg <= first_err_pair_next;
        end
    end

    // Next-state logic; completion is judged on the coverage including this sample.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = RUN;
            RUN: begin
                if (bus.start)
                    state_next = RUN;
                else if (sample && (cov_upd == 8'hFF))
                    state_next = DONE;
            end
            DONE:    if (bus.start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    // Result update: clear on start, accumulate on each sample in RUN.
    always_comb begin
        cov_next            = cov_reg;
        err_cnt_next        = err_cnt_reg;
        first_err_vec_next  = first_err_vec_reg;
        first_err_pair_next = first_err_pair_reg;
        if (bus.start) begin
            cov_next            = '0;
            err_cnt_next        = '0;
            first_err_vec_next  = '0;
            first_err_pair_next = '0;
        end else if (sample) begin
            cov_next = cov_upd;
            if (mism != 2'b00) begin
                if (err_cnt_reg != ERR_MAX)
                    err_cnt_next = err_cnt_reg + ERRW'(1);
                if (err_cnt_reg == '0) begin
                    first_err_vec_next  = bus.vec;
                    first_err_pair_next = mism;
                end
            end
        end
    end

    // Status outputs decoded from registered state only.
    always_comb begin
        busy_o = (state_reg == RUN);
        done_o = (state_reg == DONE);
        pass_o = (state_reg == DONE) && (err_cnt_reg == '0);
    end

    assign bus.busy           = busy_o;
    assign bus.done           = done_o;
    assign bus.pass           = pass_o;
    assign bus.cov            = cov_reg;
    assign bus.err_cnt        = err_cnt_reg;
    assign bus.first_err_vec  = first_err_vec_reg;
    assign bus.first_err_pair = first_err_pair_reg;
endmodule
